// File: rtl/hcxa_pkg.sv
// Shared types and the round-robin pick helper for half_cycle_xfer_arb.
package hcxa_pkg;

   localparam int MAX_NREQ = 8;
   localparam int PW       = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic          found;
      logic [PW-1:0] idx;
   } pick_t;

   // First set bit of req[0..n-1], searching upward from ptr+1 with wrap.
   function automatic pick_t rr_pick(
      input logic [MAX_NREQ-1:0] req,
      input logic [PW-1:0]       ptr,
      input int                  n
   );
      pick_t p;
      int    k;
      p = '0;
      for (int i = 1; i <= MAX_NREQ; i++) begin
         if (i <= n && !p.found) begin
            k = (int'(ptr) + i) % n;
            if (req[k]) begin
               p.found = 1'b1;
               p.idx   = PW'(k);
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/hcxa_rr_arb.sv
// Round-robin requester pick with its rotating priority pointer.
module hcxa_rr_arb
   import hcxa_pkg::*;
#(
   parameter  int NREQ = 2,
   localparam int SW   = $clog2(NREQ)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [NREQ-1:0] req_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [SW-1:0]   win_o
);

   logic [SW-1:0]       ptr_q;
   logic [SW-1:0]       ptr_d;
   logic [MAX_NREQ-1:0] req_pad;
   pick_t               pick;

   always_comb begin
      req_pad            = '0;
      req_pad[NREQ-1:0]  = req_i;
      pick               = rr_pick(req_pad, PW'(ptr_q), NREQ);
   end

   assign win_o = pick.idx[SW-1:0];
   assign gnt_o = (en_i && pick.found) ? (NREQ'(1) << win_o) : '0;
   assign ptr_d = (gnt_o != '0) ? win_o : ptr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= SW'(NREQ - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/half_cycle_xfer_arb.sv
// Posedge-launch / negedge-capture transfer arbiter.
// Define HCXA_PARITY_EN to add the registered OUT_PAR output.
module half_cycle_xfer_arb
   import hcxa_pkg::*;
#(
   parameter  int NREQ = 2,
   parameter  int DW   = 8,
   localparam int SW   = $clog2(NREQ)
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NREQ-1:0]    REQ,
   input  logic [NREQ*DW-1:0] DATA,
   output logic [NREQ-1:0]    GNT,
   output logic [DW-1:0]      OUT_DATA,
   output logic [SW-1:0]      OUT_SRC,
   output logic               OUT_VALID,
`ifdef HCXA_PARITY_EN
   output logic               OUT_PAR,
`endif
   input  logic               OUT_READY
);

   state_e          state_q;
   state_e          state_d;
   logic [DW-1:0]   l_q;
   logic [DW-1:0]   l_d;
   logic [SW-1:0]   ls_q;
   logic [SW-1:0]   ls_d;
   logic [DW-1:0]   out_data_q;
   logic [SW-1:0]   out_src_q;
   logic            out_valid_q;
   logic [SW-1:0]   win;
   logic            accept;
   logic            can_accept;
   logic            gnt_any;

   assign accept     = out_valid_q & OUT_READY;
   assign can_accept = (state_q == IDLE) | accept;
   assign gnt_any    = (GNT != '0);

   // Gate with RST_N so no grant escapes while reset is held.
   hcxa_rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .clk_i  (CLK),
      .rst_ni (RST_N),
      .req_i  (REQ),
      .en_i   (can_accept & RST_N),
      .gnt_o  (GNT),
      .win_o  (win)
   );

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      ls_d    = ls_q;
      if (gnt_any) begin
         l_d     = DATA[int'(win)*DW +: DW];
         ls_d    = win;
         state_d = BUSY;
      end else if (state_q == BUSY && accept) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         l_q     <= '0;
         ls_q    <= '0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         ls_q    <= ls_d;
      end
   end

   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
      end else if (state_q == BUSY) begin
         out_data_q  <= l_q;
         out_src_q   <= ls_q;
         out_valid_q <= 1'b1;
      end else begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef HCXA_PARITY_EN
   logic out_par_q;

   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         out_par_q <= 1'b0;
      end else if (state_q == BUSY) begin
         out_par_q <= ^l_q;
      end
   end

   assign OUT_PAR = out_par_q;
`endif

   assign OUT_DATA  = out_data_q;
   assign OUT_SRC   = out_src_q;
   assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_half_cycle_xfer_arb.sv
// Directed bench for half_cycle_xfer_arb (NREQ=2, DW=8).
// Parity checks are active when HCXA_PARITY_EN is defined.
module tb_half_cycle_xfer_arb;

   logic        CLK;
   logic        RST_N;
   logic [1:0]  REQ;
   logic [15:0] DATA;
   logic [1:0]  GNT;
   logic [7:0]  OUT_DATA;
   logic [0:0]  OUT_SRC;
   logic        OUT_VALID;
   logic        OUT_READY;
`ifdef HCXA_PARITY_EN
   logic        OUT_PAR;
`endif

   int checks;
   int passed;

   half_cycle_xfer_arb #(
      .NREQ (2),
      .DW   (8)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .REQ       (REQ),
      .DATA      (DATA),
      .GNT       (GNT),
      .OUT_DATA  (OUT_DATA),
      .OUT_SRC   (OUT_SRC),
      .OUT_VALID (OUT_VALID),
`ifdef HCXA_PARITY_EN
      .OUT_PAR   (OUT_PAR),
`endif
      .OUT_READY (OUT_READY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [7:0] d,
                          input logic s, input logic v);
      chk({tag, "_data"},  32'(OUT_DATA),  32'(d));
      chk({tag, "_src"},   32'(OUT_SRC),   32'(s));
      chk({tag, "_valid"}, 32'(OUT_VALID), 32'(v));
   endtask

   initial begin
      checks    = 0;
      passed    = 0;
      RST_N     = 1'b0;
      REQ       = 2'b00;
      DATA      = 16'h0000;
      OUT_READY = 1'b1;

      // reset held with requests pending
      #2;
      REQ  = 2'b11;
      DATA = 16'h2211;
      #10;
      chk("rst_gnt", 32'(GNT), 32'h0);
      chk_out("rst", 8'h00, 1'b0, 1'b0);
`ifdef HCXA_PARITY_EN
      chk("rst_par", 32'(OUT_PAR), 32'h0);
`endif
      #9;
      RST_N = 1'b1;
      #3;

      // fairness: 0,1,0,1 with no bubbles
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fair_gnt%0d", k), 32'(GNT),
             (k % 2 == 0) ? 32'h1 : 32'h2);
         #7;
         chk_out($sformatf("fair%0d", k),
                 (k % 2 == 0) ? 8'h11 : 8'h22, 1'(k % 2), 1'b1);
         if (k == 3) begin
            REQ       = 2'b01;
            DATA[7:0] = 8'hA5;
         end
         #3;
      end

      // single transfer
      chk("single_gnt", 32'(GNT), 32'h1);
      #2;
      REQ = 2'b00;
      #5;
      chk_out("single", 8'hA5, 1'b0, 1'b1);
      #3;
      chk("single_gnt_off", 32'(GNT), 32'h0);
      #7;
      chk("single_valid_drop", 32'(OUT_VALID), 32'h0);
      chk("single_data_hold", 32'(OUT_DATA), 32'hA5);

      // backpressure for three rising edges
      REQ        = 2'b10;
      DATA[15:8] = 8'h5C;
      #3;
      chk("bp_gnt", 32'(GNT), 32'h2);
      #2;
      REQ       = 2'b01;
      DATA[7:0] = 8'h3E;
      OUT_READY = 1'b0;
      #5;
      chk_out("bp_first", 8'h5C, 1'b1, 1'b1);
      for (int c = 0; c < 3; c++) begin
         #3;
         chk($sformatf("bp_stall_gnt%0d", c), 32'(GNT), 32'h0);
         if (c < 2) begin
            #7;
            chk_out($sformatf("bp_stall%0d", c), 8'h5C, 1'b1, 1'b1);
         end
      end
      #2;
      OUT_READY = 1'b1;
      #8;
      chk("bp_release_gnt", 32'(GNT), 32'h1);
      #2;
      REQ = 2'b00;
      #5;
      chk_out("bp_next", 8'h3E, 1'b0, 1'b1);
      #3;
      chk("bp_idle_gnt", 32'(GNT), 32'h0);
      #7;
      chk("bp_valid_drop", 32'(OUT_VALID), 32'h0);

      // reset between launch and capture
      REQ       = 2'b01;
      DATA[7:0] = 8'h99;
      #3;
      chk("mid_gnt", 32'(GNT), 32'h1);
      #3;
      RST_N = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(GNT), 32'h0);
      chk("mid_rst_valid", 32'(OUT_VALID), 32'h0);
      #3;
      chk_out("mid_rst_cap", 8'h00, 1'b0, 1'b0);
      #1;
      REQ       = 2'b11;
      DATA[7:0] = 8'h42;
      #1;
      RST_N = 1'b1;
      #1;
      chk("mid_ptr_gnt", 32'(GNT), 32'h1);
      #2;
      REQ = 2'b00;
      #5;
      chk_out("mid_after", 8'h42, 1'b0, 1'b1);
      #10;

`ifdef HCXA_PARITY_EN
      REQ       = 2'b01;
      DATA[7:0] = 8'h07;
      #5;
      DATA[7:0] = 8'h03;
      #5;
      chk_out("par07", 8'h07, 1'b0, 1'b1);
      chk("par07_par", 32'(OUT_PAR), 32'h1);
      #3;
      chk("par_gnt", 32'(GNT), 32'h1);
      #2;
      REQ = 2'b00;
      #5;
      chk_out("par03", 8'h03, 1'b0, 1'b1);
      chk("par03_par", 32'(OUT_PAR), 32'h0);
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
